// File: rtl/mic1_uart_pkg.sv
// mic1_uart_pkg: shared state type and default parameters for the MIC-1 UART RX/TX blocks
package mic1_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;
  localparam int BAUD_CLKS_DEFAULT = 1250;
  localparam int FIFO_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/mic1_sync_fifo.sv
// mic1_sync_fifo: synchronous FIFO with a registered head-of-queue output
// Ports: clk, resetn (async active-low), i_push/i_din write side,
//        i_pop read side, o_dout registered head, o_full, o_empty.
module mic1_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic [AW:0]      r_wptr, r_rptr;
  logic [AW:0]      w_rptr_n;
  logic             w_push_ok, w_pop_ok;
  assign o_empty   = r_wptr == r_rptr;
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  // a pop on the same edge frees the slot, so a push into a full FIFO is still taken
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign w_rptr_n  = r_rptr + (AW+1)'(w_pop_ok);
  assign o_dout    = r_dout;
  always_ff @(posedge clk)
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_din;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_dout <= '0;
    end else begin
      r_wptr <= r_wptr + (AW+1)'(w_push_ok);
      r_rptr <= w_rptr_n;
      // head register tracks the entry at the next read pointer; when that
      // slot is the one being written now, take the incoming data directly
      if (w_rptr_n != r_wptr) r_dout <= r_mem[w_rptr_n[AW-1:0]];
      else if (w_push_ok) r_dout <= i_din;
    end
endmodule

// File: rtl/mic1_uart_rx.sv
// mic1_uart_rx: 8N1 UART receiver with start/stop checking and a byte FIFO
// Ports: clk, resetn (async active-low), rx serial input (idles high),
//        rd_data/rd_valid/rd_ready FIFO read port (pop on valid && ready),
//        frame_err and overrun sticky flags, err_clr clears both.
module mic1_uart_rx import mic1_uart_pkg::*; #(
  parameter int CLKS_PER_BIT = BAUD_CLKS_DEFAULT,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  uart_rx_state_t r_state;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_idx;
  logic [7:0]     r_shift;
  logic           r_rx_meta, r_rx_s;
  logic           r_frame_err, r_overrun;
  logic           w_tick, w_push, w_ferr, w_drop, w_full, w_empty;
  assign w_tick    = r_cnt == '0;
  assign w_push    = r_state == STOP && w_tick && r_rx_s;
  assign w_ferr    = r_state == STOP && w_tick && !r_rx_s;
  // full implies non-empty, so rd_ready alone tells whether a pop frees a slot
  assign w_drop    = w_push && w_full && !rd_ready;
  assign rd_valid  = !w_empty;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_meta   <= rx;
      r_rx_s      <= r_rx_meta;
      r_frame_err <= w_ferr | (r_frame_err & ~err_clr);
      r_overrun   <= w_drop | (r_overrun & ~err_clr);
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt - CW'(1);
      case (r_state)
        IDLE:  if (!r_rx_s) begin
                 r_cnt   <= HALF;
                 r_state <= START;
               end
        START: if (w_tick) begin
                 r_state <= r_rx_s ? IDLE : DATA;
                 r_cnt   <= FULL;
                 r_idx   <= '0;
               end
        DATA:  if (w_tick) begin
                 r_shift[r_idx] <= r_rx_s;
                 r_cnt          <= FULL;
                 r_idx          <= r_idx + 3'd1;
                 if (r_idx == 3'd7) r_state <= STOP;
               end
        STOP:  if (w_tick) r_state <= r_rx_s ? IDLE : BREAK;
        BREAK: if (r_rx_s) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  mic1_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .i_push (w_push),
    .i_din  (r_shift),
    .i_pop  (rd_ready),
    .o_dout (rd_data),
    .o_full (w_full),
    .o_empty(w_empty)
  );
endmodule
